run_monitor: RTL and testbench

//  Synthesizable run-completion monitor and state-dump engine for the 4-bit CPU system.

---
 rtl/run_monitor_if.sv | 27 ++
 rtl/run_monitor.sv | 184 ++++++++++++++++++
 tb/tb_run_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_monitor_if.sv
// rtl/run_monitor_if.sv - nibble dump stream between run_monitor and its consumer
//
// Signals:
//   dump_valid  source -> sink  nibble available
//   dump_data   source -> sink  4-bit nibble
//   dump_last   source -> sink  final nibble of the dump
//   dump_ready  sink -> source  consumer accepts the nibble
interface run_monitor_if;
    logic       dump_valid;
    logic [3:0] dump_data;
    logic       dump_last;
    logic       dump_ready;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run-completion monitor and nibble state-dump engine for the 4-bit CPU
//
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   start             arm / re-arm the monitor (pulse, honoured in IDLE and DONE)
//   sync, pc          CPU instruction-cycle strobe and program counter
//   accumulator, carry, registers, stack   CPU state captured at end of run
//   done, cause       run ended; 0 none, 1 end-of-rom, 2 spin, 3 timeout
//   sync_error        sticky flag for sync spacing other than CYCLES_PER_INSN
//   insn_count        syncs seen in RUN, saturating
//   cycle_count       clocks spent in RUN, saturating
//   dump              nibble stream (master side of run_monitor_if)
module run_monitor #(
    parameter int ROM_SIZE        = 256,
    parameter int PC_WIDTH        = 12,
    parameter int NUM_REGS        = 16,
    parameter int STACK_DEPTH     = 4,
    parameter int CYCLES_PER_INSN = 8,
    parameter int SPIN_LIMIT      = 4,
    parameter int TIMEOUT         = 65536
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            sync,
    input  logic [PC_WIDTH-1:0]             pc,
    input  logic [3:0]                      accumulator,
    input  logic                            carry,
    input  logic [4*NUM_REGS-1:0]           registers,
    input  logic [PC_WIDTH*STACK_DEPTH-1:0] stack,
    output logic                            done,
    output logic [1:0]                      cause,
    output logic                            sync_error,
    output logic [31:0]                     insn_count,
    output logic [31:0]                     cycle_count,
    run_monitor_if.master                   dump
);

    localparam int NIBBLES = 2 + NUM_REGS + STACK_DEPTH * PC_WIDTH / 4;
    localparam int SNAP_W  = 4 * NIBBLES;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [31:0] SAT       = 32'hFFFF_FFFF;
    localparam logic [31:0] ROM_LIMIT = 32'(ROM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t                state;
    logic [SNAP_W-1:0]     snapshot;
    logic [IDX_W-1:0]      idx;
    logic [PC_WIDTH-1:0]   prev_pc;
    logic                  have_prev;
    logic [15:0]           repeat_cnt;
    logic                  seen_sync;
    logic [15:0]           gap_cnt;

    logic [31:0]           insn_next;
    logic [31:0]           cycle_next;
    logic [15:0]           repeat_next;
    logic                  end_of_rom;
    logic                  spin_hit;
    logic                  timeout_hit;
    logic [1:0]            hit_cause;
    logic [SNAP_W-1:0]     snap_next;

    // Nibble k of the dump lives at snapshot[4k +: 4]; the concatenation
    // order below is therefore the stream order read from bit 0 upward.
    assign snap_next = {stack, registers, 3'b000, carry, accumulator};

    assign insn_next  = (insn_count == SAT)  ? insn_count  : insn_count + 32'd1;
    assign cycle_next = (cycle_count == SAT) ? cycle_count : cycle_count + 32'd1;

    always_comb begin
        repeat_next = 16'd0;
        if (have_prev && pc == prev_pc) begin
            repeat_next = (repeat_cnt == 16'hFFFF) ? repeat_cnt : repeat_cnt + 16'd1;
        end
    end

    assign end_of_rom  = 32'(pc) >= ROM_LIMIT;
    assign spin_hit    = (SPIN_LIMIT != 0) && (32'(repeat_next) >= 32'(SPIN_LIMIT));
    assign timeout_hit = (TIMEOUT != 0) && (insn_next == 32'(TIMEOUT));

    always_comb begin
        hit_cause = 2'd0;
        if (end_of_rom)       hit_cause = 2'd1;
        else if (spin_hit)    hit_cause = 2'd2;
        else if (timeout_hit) hit_cause = 2'd3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            done            <= 1'b0;
            cause           <= 2'd0;
            sync_error      <= 1'b0;
            insn_count      <= 32'd0;
            cycle_count     <= 32'd0;
            snapshot        <= '0;
            idx             <= '0;
            prev_pc         <= '0;
            have_prev       <= 1'b0;
            repeat_cnt      <= 16'd0;
            seen_sync       <= 1'b0;
            gap_cnt         <= 16'd0;
            dump.dump_valid <= 1'b0;
            dump.dump_data  <= 4'd0;
            dump.dump_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        done        <= 1'b0;
                        cause       <= 2'd0;
                        sync_error  <= 1'b0;
                        insn_count  <= 32'd0;
                        cycle_count <= 32'd0;
                        have_prev   <= 1'b0;
                        repeat_cnt  <= 16'd0;
                        seen_sync   <= 1'b0;
                        gap_cnt     <= 16'd0;
                    end
                end

                ST_RUN: begin
                    cycle_count <= cycle_next;
                    // gap_cnt holds the number of clocks since the previous sync
                    // at the moment the next one arrives.
                    if (sync) begin
                        gap_cnt <= 16'd1;
                    end else if (gap_cnt != 16'hFFFF) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end

                    if (sync) begin
                        insn_count <= insn_next;
                        have_prev  <= 1'b1;
                        prev_pc    <= pc;
                        repeat_cnt <= repeat_next;
                        seen_sync  <= 1'b1;
                        if (seen_sync && gap_cnt != 16'(CYCLES_PER_INSN)) begin
                            sync_error <= 1'b1;
                        end
                        if (hit_cause != 2'd0) begin
                            state           <= ST_DUMP;
                            cause           <= hit_cause;
                            done            <= 1'b1;
                            snapshot        <= snap_next;
                            idx             <= '0;
                            dump.dump_valid <= 1'b1;
                            // Snapshot is only being written now, so take the
                            // first nibble straight from the live input.
                            dump.dump_data  <= accumulator;
                            dump.dump_last  <= (NIBBLES == 1);
                        end
                    end
                end

                ST_DUMP: begin
                    if (dump.dump_valid && dump.dump_ready) begin
                        if (dump.dump_last) begin
                            state           <= ST_DONE;
                            dump.dump_valid <= 1'b0;
                            dump.dump_last  <= 1'b0;
                            dump.dump_data  <= 4'd0;
                        end else begin
                            idx            <= idx + IDX_W'(1);
                            dump.dump_data <= snapshot[4*(int'(idx)+1) +: 4];
                            dump.dump_last <= (int'(idx) + 1 == NIBBLES - 1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - directed self-checking bench for run_monitor
module tb_run_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a;
    logic        start_b;
    logic        sync;
    logic [11:0] pc;
    logic [3:0]  acc;
    logic        carry;
    logic [63:0] regs;
    logic [47:0] stk;

    logic        done_a, done_b;
    logic [1:0]  cause_a, cause_b;
    logic        serr_a, serr_b;
    logic [31:0] insn_a, insn_b;
    logic [31:0] cyc_a, cyc_b;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_a [0:29];

    run_monitor_if if_a ();
    run_monitor_if if_b ();

    run_monitor u_a (
        .clock(clock), .reset(reset), .start(start_a), .sync(sync), .pc(pc),
        .accumulator(acc), .carry(carry), .registers(regs), .stack(stk),
        .done(done_a), .cause(cause_a), .sync_error(serr_a),
        .insn_count(insn_a), .cycle_count(cyc_a), .dump(if_a)
    );

    run_monitor #(.TIMEOUT(20)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .sync(sync), .pc(pc),
        .accumulator(acc), .carry(carry), .registers(regs), .stack(stk),
        .done(done_b), .cause(cause_b), .sync_error(serr_b),
        .insn_count(insn_b), .cycle_count(cyc_b), .dump(if_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_sync(input logic [11:0] p, input int gap);
        sync = 1'b1;
        pc   = p;
        tick();
        sync = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic set_cpu(input logic [3:0] a, input logic c, input int seed);
        acc   = a;
        carry = c;
        for (int i = 0; i < 16; i++) regs[4*i +: 4] = 4'(i * 3 + seed);
        for (int k = 0; k < 4; k++) stk[12*k +: 12] = 12'(12'h123 * (k + 1) + seed);
    endtask

    // Expected stream from the values the bench is currently driving.
    task automatic capture_a();
        for (int k = 0; k < 30; k++) begin
            if (k == 0)       exp_a[k] = acc;
            else if (k == 1)  exp_a[k] = {3'b000, carry};
            else if (k < 18)  exp_a[k] = regs[4*(k-2) +: 4];
            else              exp_a[k] = stk[12*((k-18)/3) + 4*((k-18)%3) +: 4];
        end
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sync    = 1'b0;
        pc      = '0;
        if_a.dump_ready = 1'b0;
        if_b.dump_ready = 1'b0;
        set_cpu(4'h0, 1'b0, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_done", 32'(done_a), 32'd0);
        check("rst_cause", 32'(cause_a), 32'd0);
        check("rst_valid", 32'(if_a.dump_valid), 32'd0);
        check("rst_insn", insn_a, 32'd0);
        check("rst_cycle", cyc_a, 32'd0);
        check("rst_serr", 32'(serr_a), 32'd0);

        // Syncs without start are ignored.
        for (int i = 0; i < 20; i++) do_sync(12'(i), 8);
        check("t1_insn", insn_a, 32'd0);
        check("t1_done", 32'(done_a), 32'd0);
        check("t1_valid", 32'(if_a.dump_valid), 32'd0);

        // End of ROM.
        set_cpu(4'hA, 1'b1, 3);
        pulse_start_a();
        for (int i = 0; i < 256; i++) do_sync(12'(i), 8);
        check("t2_notdone", 32'(done_a), 32'd0);
        capture_a();
        do_sync(12'd256, 1);
        check("t2_cause", 32'(cause_a), 32'd1);
        check("t2_insn", insn_a, 32'd257);
        check("t2_done", 32'(done_a), 32'd1);
        check("t2_serr", 32'(serr_a), 32'd0);
        set_cpu(4'h0, 1'b0, 9);
        if_a.dump_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            check("t2_valid", 32'(if_a.dump_valid), 32'd1);
            check($sformatf("t2_data%0d", k), 32'(if_a.dump_data), 32'(exp_a[k]));
            check("t2_last", 32'(if_a.dump_last), 32'(k == 29));
            tick();
        end
        check("t2_end_valid", 32'(if_a.dump_valid), 32'd0);
        check("t2_end_done", 32'(done_a), 32'd1);
        check("t2_end_cause", 32'(cause_a), 32'd1);
        if_a.dump_ready = 1'b0;

        // Spin halt.
        set_cpu(4'h5, 1'b0, 7);
        pulse_start_a();
        check("t3_cause_clr", 32'(cause_a), 32'd0);
        do_sync(12'h010, 8);
        for (int j = 0; j < 4; j++) do_sync(12'h011, 8);
        check("t3_notdone", 32'(done_a), 32'd0);
        check("t3_insn5", insn_a, 32'd5);
        capture_a();
        do_sync(12'h011, 1);
        check("t3_cause", 32'(cause_a), 32'd2);
        check("t3_insn", insn_a, 32'd6);
        set_cpu(4'hF, 1'b1, 1);

        // Timeout, then end-of-rom priority over timeout.
        pulse_start_b();
        for (int i = 0; i < 19; i++) do_sync(12'(i % 4), 8);
        check("t4_notdone", 32'(done_b), 32'd0);
        do_sync(12'd3, 1);
        check("t4_cause", 32'(cause_b), 32'd3);
        check("t4_insn", insn_b, 32'd20);
        if_b.dump_ready = 1'b1;
        repeat (35) tick();
        check("t4_drain_valid", 32'(if_b.dump_valid), 32'd0);
        check("t4_drain_done", 32'(done_b), 32'd1);
        if_b.dump_ready = 1'b0;
        pulse_start_b();
        for (int i = 0; i < 19; i++) do_sync(12'(i % 4), 8);
        do_sync(12'd256, 1);
        check("t4_prio_cause", 32'(cause_b), 32'd1);
        check("t4_prio_insn", insn_b, 32'd20);

        // Stalled dump of the spin snapshot, reset at the 10th nibble.
        begin
            int count = 0;
            for (int cyc = 0; cyc < 200 && count < 9; cyc++) begin
                if_a.dump_ready = (cyc % 3 == 2);
                check("t5_valid", 32'(if_a.dump_valid), 32'd1);
                check($sformatf("t5_data%0d", count), 32'(if_a.dump_data), 32'(exp_a[count]));
                check("t5_last", 32'(if_a.dump_last), 32'd0);
                if (if_a.dump_ready) count++;
                tick();
            end
            check("t5_count", 32'(count), 32'd9);
            if_a.dump_ready = 1'b0;
            check("t5_data9", 32'(if_a.dump_data), 32'(exp_a[9]));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_valid", 32'(if_a.dump_valid), 32'd0);
        check("t5_rst_data", 32'(if_a.dump_data), 32'd0);
        check("t5_rst_last", 32'(if_a.dump_last), 32'd0);
        check("t5_rst_done", 32'(done_a), 32'd0);
        check("t5_rst_cause", 32'(cause_a), 32'd0);
        check("t5_rst_insn", insn_a, 32'd0);
        check("t5_rst_cycle", cyc_a, 32'd0);

        // Bad sync spacing: flagged but the run continues.
        pulse_start_a();
        do_sync(12'd0, 7);
        check("t6_serr_first", 32'(serr_a), 32'd0);
        do_sync(12'd1, 7);
        check("t6_serr", 32'(serr_a), 32'd1);
        do_sync(12'd2, 7);
        do_sync(12'd3, 7);
        do_sync(12'd4, 7);
        check("t6_insn", insn_a, 32'd5);
        check("t6_cycle", cyc_a, 32'd35);
        check("t6_running", 32'(done_a), 32'd0);
        do_sync(12'd256, 1);
        check("t6_cause", 32'(cause_a), 32'd1);
        check("t6_cycle_hit", cyc_a, 32'd36);
        if_a.dump_ready = 1'b1;
        repeat (32) tick();
        if_a.dump_ready = 1'b0;
        check("t6_done", 32'(done_a), 32'd1);
        check("t6_valid", 32'(if_a.dump_valid), 32'd0);
        check("t6_cycle_frozen", cyc_a, 32'd36);
        check("t6_serr_sticky", 32'(serr_a), 32'd1);
        pulse_start_a();
        check("t6_restart_serr", 32'(serr_a), 32'd0);
        check("t6_restart_insn", insn_a, 32'd0);
        check("t6_restart_cycle", cyc_a, 32'd0);
        check("t6_restart_done", 32'(done_a), 32'd0);
        check("t6_restart_cause", 32'(cause_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
